eg2000_key_paster: RTL

- Keystroke injection stage between the tape player's 6-character system-tape filename and the eg2000 machine's `ps2_key` input.
- On a start request it converts the ASCII filename into timed PS/2 make/break events, including shift-wrapped events for `*`. Otherwise it passes the user keyboard stream through unchanged.
- Replaces the ad-hoc paste logic in the top level with a self-contained sequencer.

---
 rtl/eg2000_key_paster.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/eg2000_key_paster.sv
// Keystroke paster: turns the latched 6-character tape filename into timed PS/2 make/break events,
// otherwise passes the live keyboard through. Define EG2000_PASTE_CR_EN to append a Return key.
module eg2000_key_paster #(
    parameter int CHARS    = 6,
    parameter int GAP_BITS = 21
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [8*CHARS-1:0]   filename,
    input  logic [10:0]          ps2_user,
    output logic [10:0]          ps2_out,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W = (CHARS > 1) ? $clog2(CHARS) : 1;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_SHIFT_DN = 4'd2;
    localparam logic [3:0] S_KEY_DN   = 4'd3;
    localparam logic [3:0] S_KEY_UP   = 4'd4;
    localparam logic [3:0] S_SHIFT_UP = 4'd5;
    localparam logic [3:0] S_NEXT     = 4'd6;
    localparam logic [3:0] S_FINISH   = 4'd7;
`ifdef EG2000_PASTE_CR_EN
    localparam logic [3:0] S_CR_DN    = 4'd8;
    localparam logic [3:0] S_CR_UP    = 4'd9;
    localparam logic [3:0] S_TAIL     = S_CR_DN;
`else
    localparam logic [3:0] S_TAIL     = S_FINISH;
`endif

    localparam logic [7:0] SC_SHIFT  = 8'h12;
    localparam logic [7:0] SC_RETURN = 8'h5A;
    localparam logic [7:0] CH_STAR   = 8'h2A;

    logic [3:0]          state_q, state_d;
    logic [GAP_BITS-1:0] gap_q, gap_d;
    logic [8*CHARS-1:0]  str_q, str_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [10:0]         event_q, event_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                start_q;

    logic                start_edge;
    logic                gap_expired;
    logic [7:0]          top_ch;
    logic [8:0]          key;

    // Returns {valid, scancode}; lowercase folds onto the uppercase codes.
    function automatic logic [8:0] scan_lookup(input logic [7:0] ch);
        logic [7:0] uc;
        uc = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
        case (uc)
            8'h20: return {1'b1, 8'h29};
            8'h2A: return {1'b1, 8'h4E};
            8'h2E: return {1'b1, 8'h49};
            8'h40: return {1'b1, 8'h54};
            8'h30: return {1'b1, 8'h45};
            8'h31: return {1'b1, 8'h16};
            8'h32: return {1'b1, 8'h1E};
            8'h33: return {1'b1, 8'h26};
            8'h34: return {1'b1, 8'h25};
            8'h35: return {1'b1, 8'h2E};
            8'h36: return {1'b1, 8'h36};
            8'h37: return {1'b1, 8'h3D};
            8'h38: return {1'b1, 8'h3E};
            8'h39: return {1'b1, 8'h46};
            8'h41: return {1'b1, 8'h1C};
            8'h42: return {1'b1, 8'h32};
            8'h43: return {1'b1, 8'h21};
            8'h44: return {1'b1, 8'h23};
            8'h45: return {1'b1, 8'h24};
            8'h46: return {1'b1, 8'h2B};
            8'h47: return {1'b1, 8'h34};
            8'h48: return {1'b1, 8'h33};
            8'h49: return {1'b1, 8'h43};
            8'h4A: return {1'b1, 8'h3B};
            8'h4B: return {1'b1, 8'h42};
            8'h4C: return {1'b1, 8'h4B};
            8'h4D: return {1'b1, 8'h3A};
            8'h4E: return {1'b1, 8'h31};
            8'h4F: return {1'b1, 8'h44};
            8'h50: return {1'b1, 8'h4D};
            8'h51: return {1'b1, 8'h15};
            8'h52: return {1'b1, 8'h2D};
            8'h53: return {1'b1, 8'h1B};
            8'h54: return {1'b1, 8'h2C};
            8'h55: return {1'b1, 8'h3C};
            8'h56: return {1'b1, 8'h2A};
            8'h57: return {1'b1, 8'h1D};
            8'h58: return {1'b1, 8'h22};
            8'h59: return {1'b1, 8'h35};
            8'h5A: return {1'b1, 8'h1A};
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic [10:0] make_event(input logic prev_toggle, input logic pressed,
                                               input logic [7:0] code);
        return {~prev_toggle, pressed, 1'b0, code};
    endfunction

    always_comb begin
        start_edge  = start & ~start_q;
        gap_expired = (gap_q == '0);
        top_ch      = str_q[8*CHARS-1 -: 8];
        key         = scan_lookup(top_ch);

        // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
        state_d = state_q;
        gap_d   = gap_expired ? gap_q : gap_q - 1'b1;
        str_d   = str_q;
        idx_d   = idx_q;
        event_d = event_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // busy stays up through the done cycle and drops one cycle later.
                if (done_q) begin
                    busy_d = 1'b0;
                end else if (start_edge) begin
                    str_d   = filename;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (top_ch == 8'h00)      state_d = S_TAIL;
                else if (!key[8])         state_d = S_NEXT;
                else if (top_ch == CH_STAR) state_d = S_SHIFT_DN;
                else                      state_d = S_KEY_DN;
            end
            S_SHIFT_DN: if (gap_expired) begin
                event_d = make_event(event_q[10], 1'b1, SC_SHIFT);
                gap_d   = '1;
                state_d = S_KEY_DN;
            end
            S_KEY_DN: if (gap_expired) begin
                event_d = make_event(event_q[10], 1'b1, key[7:0]);
                gap_d   = '1;
                state_d = S_KEY_UP;
            end
            S_KEY_UP: if (gap_expired) begin
                event_d = make_event(event_q[10], 1'b0, key[7:0]);
                gap_d   = '1;
                state_d = (top_ch == CH_STAR) ? S_SHIFT_UP : S_NEXT;
            end
            S_SHIFT_UP: if (gap_expired) begin
                event_d = make_event(event_q[10], 1'b0, SC_SHIFT);
                gap_d   = '1;
                state_d = S_NEXT;
            end
            S_NEXT: if (gap_expired) begin
                str_d   = str_q << 8;
                idx_d   = idx_q + IDX_W'(1);
                state_d = (idx_q == IDX_W'(CHARS - 1)) ? S_TAIL : S_FETCH;
            end
`ifdef EG2000_PASTE_CR_EN
            S_CR_DN: if (gap_expired) begin
                event_d = make_event(event_q[10], 1'b1, SC_RETURN);
                gap_d   = '1;
                state_d = S_CR_UP;
            end
            S_CR_UP: if (gap_expired) begin
                event_d = make_event(event_q[10], 1'b0, SC_RETURN);
                gap_d   = '1;
                state_d = S_FINISH;
            end
`endif
            S_FINISH: if (gap_expired) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            str_q   <= '0;
            idx_q   <= '0;
            event_q <= 11'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            str_q   <= str_d;
            idx_q   <= idx_d;
            event_q <= event_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start;
        end
    end

    assign ps2_out = busy_q ? event_q : ps2_user;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
